// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder
//   Parallel-to-serial front end. It accepts WIDTH-bit words over a
//   valid/ready handshake and shifts them out one bit per clock on `data`.
//   A one-word hold buffer lets consecutive words stream with no idle bit
//   between them. When no word is in flight, `data` is parked at IDLE_BIT.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   din        parallel word
//   din_valid  din holds a word
//   din_ready  block can take din this cycle (combinational, from registers only)
//   data       serial bit (registered)
//   data_valid data carries a word bit (registered)
//   word_start first bit of a word is on data (registered)
//   word_done  last bit of a word is on data (registered)
//   busy       shifting, or hold buffer occupied
module serial_bit_feeder #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             data,
    output logic             data_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             word_start_q, word_start_d;
    logic             word_done_q, word_done_d;

    // Words re-ordered into transmit order, so index k is the k-th bit sent.
    logic [WIDTH-1:0] shift_ord, hold_ord;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ord
        if (MSB_FIRST) begin : g_msb
            assign shift_ord[i] = shift_q[WIDTH-1-i];
            assign hold_ord[i]  = hold_q[WIDTH-1-i];
        end else begin : g_lsb
            assign shift_ord[i] = shift_q[i];
            assign hold_ord[i]  = hold_q[i];
        end
    end

    logic last_bit, shift_load, accept;

    assign last_bit   = (state_q == S_SHIFT) && (cnt_q == LAST);
    assign shift_load = hold_full_q && ((state_q == S_IDLE) || last_bit);
    assign din_ready  = !hold_full_q || shift_load;
    assign accept     = din_valid && din_ready;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        data_d       = IDLE_BIT;
        data_valid_d = 1'b0;
        word_start_d = 1'b0;
        word_done_d  = 1'b0;

        // A simultaneous accept and load refills the buffer on the same edge.
        if (accept) hold_d = din;
        hold_full_d = accept || (hold_full_q && !shift_load);

        unique case (state_q)
            S_IDLE: begin
                if (shift_load) begin
                    // Loading from idle also launches bit 0 straight from the
                    // hold buffer, giving a one-cycle accept-to-first-bit
                    // latency; the counter then points at bit 1.
                    shift_d      = hold_q;
                    data_d       = hold_ord[0];
                    data_valid_d = 1'b1;
                    word_start_d = 1'b1;
                    cnt_d        = CW'(1);
                    state_d      = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d       = shift_ord[cnt_q];
                data_valid_d = 1'b1;
                word_start_d = (cnt_q == '0);
                word_done_d  = last_bit;
                if (last_bit) begin
                    // Reloading here keeps the next word's first bit in the
                    // cycle right after this word's last bit.
                    cnt_d = '0;
                    if (shift_load) shift_d = hold_q;
                    else            state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            data_q       <= IDLE_BIT;
            data_valid_q <= 1'b0;
            word_start_q <= 1'b0;
            word_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            word_start_q <= word_start_d;
            word_done_q  <= word_done_d;
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign word_start = word_start_q;
    assign word_done  = word_done_q;
    assign busy       = (state_q == S_SHIFT) || hold_full_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: an MSB-first and an LSB-first
// instance (WIDTH=8, IDLE_BIT=0) sharing clock and reset.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din_m, din_l;
    logic       vld_m, vld_l;
    logic       rdy_m, rdy_l, d_m, d_l, dv_m, dv_l;
    logic       ws_m, ws_l, wd_m, wd_l, bsy_m, bsy_l;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
        .clk(clk), .reset(reset), .din(din_m), .din_valid(vld_m), .din_ready(rdy_m),
        .data(d_m), .data_valid(dv_m), .word_start(ws_m), .word_done(wd_m), .busy(bsy_m)
    );

    serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
        .clk(clk), .reset(reset), .din(din_l), .din_valid(vld_l), .din_ready(rdy_l),
        .data(d_l), .data_valid(dv_l), .word_start(ws_l), .word_done(wd_l), .busy(bsy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One word into each instance; em/el are the expected streams in send order.
    task automatic single_word(input logic [7:0] dm, input logic [7:0] dl,
                               input logic [7:0] em, input logic [7:0] el, input string tag);
        din_m = dm; din_l = dl; vld_m = 1'b1; vld_l = 1'b1;
        step();                                  // accept edge N
        vld_m = 1'b0; vld_l = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();                              // cycle N+k
            chk($sformatf("%s_m_bit%0d", tag, k), d_m, em[8-k]);
            chk($sformatf("%s_l_bit%0d", tag, k), d_l, el[8-k]);
            chk($sformatf("%s_m_dv%0d", tag, k), dv_m, 1'b1);
            chk($sformatf("%s_l_dv%0d", tag, k), dv_l, 1'b1);
            chk($sformatf("%s_m_ws%0d", tag, k), ws_m, (k == 1));
            chk($sformatf("%s_m_wd%0d", tag, k), wd_m, (k == 8));
        end
        step();                                  // cycle N+9
        chk({tag, "_m_dv_end"}, dv_m, 1'b0);
        chk({tag, "_m_d_end"},  d_m,  1'b0);
        chk({tag, "_l_dv_end"}, dv_l, 1'b0);
        chk({tag, "_m_busy_end"}, bsy_m, 1'b0);
    endtask

    // Three words with din_valid held high on the MSB instance. With wig set,
    // din changes every cycle (0x30+t before edge t) and only values present
    // at accepting edges must appear on the line.
    task automatic run_stream(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                              input bit wig, input string tag);
        logic [7:0]  src [3];
        int          acc_e [3];
        logic [23:0] bits;
        logic        acc;
        int idx, nv, ns, nd, first, last;
        src = '{w0, w1, w2};
        acc_e = '{-1, -1, -1};
        bits = '0; idx = 0; nv = 0; ns = 0; nd = 0; first = -1; last = -1;
        din_m = wig ? 8'h31 : w0;
        vld_m = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            acc = vld_m && rdy_m;
            step();
            if (acc && idx < 3) begin
                acc_e[idx] = t;
                idx++;
                if (idx == 3) vld_m = 1'b0;
            end
            din_m = wig ? 8'(8'h30 + t + 1) : src[(idx < 3) ? idx : 2];
            if (dv_m) begin
                if (first < 0) first = t;
                last = t;
                bits = {bits[22:0], d_m};
                nv++;
            end
            ns += int'(ws_m);
            nd += int'(wd_m);
        end
        chk({tag, "_acc0"}, acc_e[0], 1);
        chk({tag, "_acc1"}, acc_e[1], 2);
        chk({tag, "_acc2"}, acc_e[2], 9);
        chk({tag, "_nvalid"}, nv, 24);
        chk({tag, "_first"}, first, 2);
        chk({tag, "_span"}, last - first + 1, 24);
        chk({tag, "_starts"}, ns, 3);
        chk({tag, "_dones"}, nd, 3);
        chk({tag, "_stream"}, bits, {w0, w1, w2});
    endtask

    initial begin
        int nv;
        reset = 1'b1;
        din_m = '0; din_l = '0; vld_m = 1'b0; vld_l = 1'b0;
        #2;
        chk("rst_data",  d_m,   1'b0);
        chk("rst_dv",    dv_m,  1'b0);
        chk("rst_busy",  bsy_m, 1'b0);
        chk("rst_ready", rdy_m, 1'b1);
        chk("rst_ready_l", rdy_l, 1'b1);
        step();
        #3 reset = 1'b0;
        step();

        // 0xB4 MSB-first and 0x2D LSB-first both give 1,0,1,1,0,1,0,0
        single_word(8'hB4, 8'h2D, 8'hB4, 8'hB4, "sw");
        step();

        run_stream(8'hB4, 8'h2D, 8'hFF, 1'b0, "b2b");
        step();
        run_stream(8'h31, 8'h32, 8'h39, 1'b1, "bp");
        step();

        // Reset after three bits of 0xB4 with 0x2D held
        din_m = 8'hB4; vld_m = 1'b1;
        step();
        din_m = 8'h2D;
        step();
        vld_m = 1'b0;
        step();
        step();
        chk("mid_dv",    dv_m,  1'b1);
        chk("mid_busy",  bsy_m, 1'b1);
        chk("mid_ready", rdy_m, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("arst_data",  d_m,   1'b0);
        chk("arst_dv",    dv_m,  1'b0);
        chk("arst_ws",    ws_m,  1'b0);
        chk("arst_busy",  bsy_m, 1'b0);
        chk("arst_ready", rdy_m, 1'b1);
        #1 reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            nv += int'(dv_m);
        end
        chk("arst_no_bits", nv, 0);

        // 0x0F: MSB-first 0,0,0,0,1,1,1,1; LSB-first 1,1,1,1,0,0,0,0
        single_word(8'h0F, 8'h0F, 8'h0F, 8'hF0, "post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
